fx68k_phase_gen: RTL and testbench
==================================

Name: fx68k_phase_gen

Overview:
- Produces the s_clks struct (extReset, pwrUp, enPhi1, enPhi2) that every fx68k stage consumes.
- Divides the system clock into alternating PHI1/PHI2 clock-enable pulses.
- Supports a hold/stall input.
- Stretches the emulated-system reset so the core sees a minimum number of running phase pairs while in reset.
- Sits at the top of the CPU wrapper, directly upstream of the core.

Parameters:
- DIV, 1: system clocks per CPU phase; legal 1..255. Counter width is clog2(DIV), minimum 1.
- RST_STRETCH, 8: enPhi2 pulses clks.extReset stays asserted after extReset is released; legal 0..65535; 16-bit counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- extReset  in  1  synchronous, active-high reset; also the emulated-system reset request.
- pwrUpIn  in  1  cold-start flag, meaningful only while extReset=1.
- phiHold  in  1  freezes phase generation while high.
- clks  out  4  packed s_clks: [3]=extReset, [2]=pwrUp, [1]=enPhi1, [0]=enPhi2.
- phiState  out  1  0 = next enable issued is enPhi1; 1 = next is enPhi2.
- rstBusy  out  1  equals clks.extReset; convenience copy for the bus interface.

Behaviour:
- All outputs are registered.
- **Reset (any edge sampling extReset=1):**
  - divCnt=0, phiState=0, stretchCnt=0, enPhi1=0, enPhi2=0.
  - clks.extReset=1, rstBusy=1.
  - pwrUp latch |= pwrUpIn.
  - Values are visible the cycle after the sampling edge.
- **Phase generation (extReset=0):**
  - Each edge with phiHold=0: if divCnt==DIV-1, divCnt=0, assert the enable selected by phiState for exactly one cycle, then toggle phiState. Otherwise divCnt+1 and both enables 0.
  - Each edge with phiHold=1: divCnt, phiState and stretchCnt frozen; both enables 0. Generation resumes exactly where it stopped; no pulse is lost or duplicated.
  - enPhi1 and enPhi2 are never both 1, and never 1 in consecutive cycles when DIV>1.
- **Timing:**
  - Let edge k be the first edge sampling extReset=0 after reset.
  - With phiHold=0, enPhi1 is high in the cycle after edge k+DIV-1.
  - enPhi2 is high DIV cycles after that, alternating thereafter.
  - DIV=1: enPhi1 in the cycle following edge k, then strict alternation every cycle.
- **Reset stretch:**
  - After release, stretchCnt counts issued enPhi2 pulses.
  - The edge that registers the RST_STRETCH-th enPhi2 pulse also clears clks.extReset, pwrUp and rstBusy. They are therefore low starting the cycle after that pulse is visible.
  - If RST_STRETCH=0, they clear at edge k, i.e. the first cycle after release.
  - stretchCnt saturates; it never wraps.
- **pwrUp:**
  - Set only while extReset=1 and pwrUpIn=1.
  - Cleared only at stretch end.
  - Never asserted when clks.extReset=0.
- **Re-assertion:** extReset reasserted mid-stretch or mid-operation restarts everything per the reset rule. A pending pwrUp is preserved (OR-latched), not cleared.
- **phiHold during stretch:** no enPhi2 is issued, so the stretch is extended by the hold duration.
- **Simultaneous events:** extReset=1 overrides phiHold and any pending enable; no enable is issued on that edge.

Test Plan:
1. DIV=1, RST_STRETCH=2, pwrUpIn=1 for 3 reset cycles, then release.
   - Required: clks = 4'b1110, then 1101, then 1110, then 1101.
   - clks[3:2] drop to 00 the cycle after the 2nd enPhi2.
2. DIV=3, phiHold=0: enPhi1 on cycles k+3, k+9, k+15; enPhi2 on k+6, k+12. Each pulse is one cycle wide.
3. DIV=2: phiHold=1 for 5 cycles starting the cycle after enPhi1.
   - Required: no enables during the hold.
   - enPhi2 appears 2 cycles after phiHold drops; phiState stays 1 throughout the hold.
4. RST_STRETCH=4: extReset reasserted for 1 cycle after 2 enPhi2 pulses.
   - Required: pwrUp stays set, stretchCnt restarts.
   - clks.extReset clears only after 4 new enPhi2 pulses.
5. RST_STRETCH=0, pwrUpIn=0: clks.extReset=0 and pwrUp=0 the cycle after release; first enPhi1 per DIV timing.
6. Random phiHold/extReset soak, DIV in {1,2,5}.
   - Assert never (enPhi1 & enPhi2).
   - Assert enables strictly alternate, starting with enPhi1 after each reset.
   - Assert never (pwrUp & !extReset).

Source files
------------

// File: rtl/fx68k_phase_gen.sv
// Phase-enable generator for the fx68k core: builds the s_clks bundle
// {extReset, pwrUp, enPhi1, enPhi2} and stretches the system reset.
module fx68k_phase_gen #(
   parameter int DIV         = 1,
   parameter int RST_STRETCH = 8
) (
   input  logic       clk,
   input  logic       extReset,
   input  logic       pwrUpIn,
   input  logic       phiHold,
   output logic [3:0] clks,
   output logic       phiState,
   output logic       rstBusy
);

   localparam int             CW          = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  DIV_LAST    = CW'(DIV - 1);
   localparam logic [15:0]    STRETCH_LEN = 16'(RST_STRETCH);

   logic [CW-1:0] div_cnt,     div_cnt_nxt;
   logic [15:0]   stretch_cnt, stretch_cnt_nxt;
   logic          phi_state_q, phi_state_nxt;
   logic          en_phi1,     en_phi1_nxt;
   logic          en_phi2,     en_phi2_nxt;
   logic          ext_rst_q,   ext_rst_nxt;
   logic          pwr_up_q,    pwr_up_nxt;

   // NOTE: state registers take non-blocking assignments so every flop
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk) begin
      div_cnt     <= div_cnt_nxt;
      stretch_cnt <= stretch_cnt_nxt;
      phi_state_q <= phi_state_nxt;
      en_phi1     <= en_phi1_nxt;
      en_phi2     <= en_phi2_nxt;
      ext_rst_q   <= ext_rst_nxt;
      pwr_up_q    <= pwr_up_nxt;
   end

   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      div_cnt_nxt     = div_cnt;
      stretch_cnt_nxt = stretch_cnt;
      phi_state_nxt   = phi_state_q;
      en_phi1_nxt     = 1'b0;
      en_phi2_nxt     = 1'b0;
      ext_rst_nxt     = ext_rst_q;
      pwr_up_nxt      = pwr_up_q;

      if (extReset) begin
         div_cnt_nxt     = '0;
         stretch_cnt_nxt = '0;
         phi_state_nxt   = 1'b0;
         ext_rst_nxt     = 1'b1;
         pwr_up_nxt      = pwr_up_q | pwrUpIn;
      end else begin
         // Count reaches the target on the edge issuing the last enPhi2,
         // so the reset drops one cycle after that pulse is visible.
         if (stretch_cnt >= STRETCH_LEN) begin
            ext_rst_nxt = 1'b0;
            pwr_up_nxt  = 1'b0;
         end
         if (!phiHold) begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_nxt   = '0;
               en_phi1_nxt   = ~phi_state_q;
               en_phi2_nxt   = phi_state_q;
               phi_state_nxt = ~phi_state_q;
               if (phi_state_q && (stretch_cnt != 16'hFFFF))
                  stretch_cnt_nxt = stretch_cnt + 16'd1;
            end else begin
               div_cnt_nxt = div_cnt + CW'(1);
            end
         end
      end
   end

   always_comb begin
      clks     = {ext_rst_q, pwr_up_q, en_phi1, en_phi2};
      phiState = phi_state_q;
      rstBusy  = ext_rst_q;
   end

endmodule

// File: tb/tb_fx68k_phase_gen.sv
// Directed checks of fx68k_phase_gen across four DIV/RST_STRETCH builds,
// followed by a random hold/reset soak watched by invariant monitors.
module tb_fx68k_phase_gen;

   logic       clk = 1'b0;
   logic       extReset = 1'b1;
   logic       pwrUpIn = 1'b0;
   logic       phiHold = 1'b0;
   logic [3:0] clks_v [4];
   logic       phi_v  [4];
   logic       busy_v [4];

   int n_checks = 0;
   int n_pass   = 0;
   logic mon_en = 1'b0;
   logic exp_en2 [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;

   fx68k_phase_gen #(.DIV(1), .RST_STRETCH(2)) u_d1 (
      .clk(clk), .extReset(extReset), .pwrUpIn(pwrUpIn), .phiHold(phiHold),
      .clks(clks_v[0]), .phiState(phi_v[0]), .rstBusy(busy_v[0]));
   fx68k_phase_gen #(.DIV(3), .RST_STRETCH(8)) u_d3 (
      .clk(clk), .extReset(extReset), .pwrUpIn(pwrUpIn), .phiHold(phiHold),
      .clks(clks_v[1]), .phiState(phi_v[1]), .rstBusy(busy_v[1]));
   fx68k_phase_gen #(.DIV(2), .RST_STRETCH(4)) u_d2 (
      .clk(clk), .extReset(extReset), .pwrUpIn(pwrUpIn), .phiHold(phiHold),
      .clks(clks_v[2]), .phiState(phi_v[2]), .rstBusy(busy_v[2]));
   fx68k_phase_gen #(.DIV(5), .RST_STRETCH(0)) u_d5 (
      .clk(clk), .extReset(extReset), .pwrUpIn(pwrUpIn), .phiHold(phiHold),
      .clks(clks_v[3]), .phiState(phi_v[3]), .rstBusy(busy_v[3]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic step(input logic e, input logic p, input logic h);
      extReset = e;
      pwrUpIn  = p;
      phiHold  = h;
      @(posedge clk);
      #1;
   endtask

   // Any edge sampling reset means the next enable must be enPhi1.
   always @(posedge clk)
      if (extReset)
         for (int j = 0; j < 4; j++) exp_en2[j] = 1'b0;

   always @(negedge clk)
      if (mon_en)
         for (int j = 0; j < 4; j++) begin
            check($sformatf("excl%0d", j), {31'd0, clks_v[j][1] & clks_v[j][0]}, 32'd0);
            check($sformatf("pwrup_no_rst%0d", j), {31'd0, clks_v[j][2] & ~clks_v[j][3]}, 32'd0);
            if (clks_v[j][1] | clks_v[j][0]) begin
               check($sformatf("alternate%0d", j), {30'd0, clks_v[j][1:0]},
                     exp_en2[j] ? 32'd1 : 32'd2);
               exp_en2[j] = ~exp_en2[j];
            end
         end

   initial begin
      logic [3:0] t1_exp [6];
      logic [3:0] e4;
      t1_exp = '{4'b1110, 4'b1101, 4'b1110, 4'b1101, 4'b0010, 4'b0001};

      // Test 1: DIV=1, stretch 2, cold start
      repeat (3) step(1'b1, 1'b1, 1'b0);
      mon_en = 1'b1;
      check("t1_rst_clks", {28'd0, clks_v[0]}, 32'hC);
      check("t1_rst_busy", {31'd0, busy_v[0]}, 32'd1);
      check("t1_rst_phi",  {31'd0, phi_v[0]},  32'd0);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check($sformatf("t1_clks_%0d", i), {28'd0, clks_v[0]}, {28'd0, t1_exp[i]});
         check($sformatf("t1_busy_%0d", i), {31'd0, busy_v[0]}, {31'd0, t1_exp[i][3]});
      end

      // Test 2: DIV=3 pulse placement
      repeat (2) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check($sformatf("t2_en_%0d", i), {30'd0, clks_v[1][1:0]},
               {30'd0, (i == 2 || i == 8 || i == 14), (i == 5 || i == 11 || i == 17)});
      end
      check("t2_still_rst", {31'd0, clks_v[1][3]}, 32'd1);

      // Test 3: DIV=2 hold after enPhi1
      repeat (2) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("t3_k0", {30'd0, clks_v[2][1:0]}, 32'd0);
      step(1'b0, 1'b0, 1'b0);
      check("t3_phi1", {30'd0, clks_v[2][1:0]}, 32'd2);
      check("t3_state", {31'd0, phi_v[2]}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b1);
         check($sformatf("t3_hold_en_%0d", i), {30'd0, clks_v[2][1:0]}, 32'd0);
         check($sformatf("t3_hold_st_%0d", i), {31'd0, phi_v[2]}, 32'd1);
      end
      step(1'b0, 1'b0, 1'b0);
      check("t3_resume1", {30'd0, clks_v[2][1:0]}, 32'd0);
      step(1'b0, 1'b0, 1'b0);
      check("t3_resume2", {30'd0, clks_v[2][1:0]}, 32'd1);
      check("t3_state_after", {31'd0, phi_v[2]}, 32'd0);

      // Test 4: DIV=2, stretch 4, reset reasserted after two enPhi2
      repeat (2) step(1'b1, 1'b1, 1'b0);
      check("t4_rst", {28'd0, clks_v[2]}, 32'hC);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
      check("t4_second_phi2", {28'd0, clks_v[2]}, 32'hD);
      step(1'b1, 1'b0, 1'b0);
      check("t4_rerst", {28'd0, clks_v[2]}, 32'hC);
      for (int i = 0; i < 17; i++) begin
         step(1'b0, 1'b0, 1'b0);
         e4 = {(i < 16), (i < 16), (i % 4 == 1), (i % 4 == 3)};
         check($sformatf("t4_clks_%0d", i), {28'd0, clks_v[2]}, {28'd0, e4});
      end

      // Test 5: DIV=5, no stretch
      repeat (2) step(1'b1, 1'b0, 1'b0);
      check("t5_rst", {28'd0, clks_v[3]}, 32'h8);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check($sformatf("t5_clks_%0d", i), {28'd0, clks_v[3]}, {30'd0, (i == 4), 1'b0});
      end
      check("t5_busy", {31'd0, busy_v[3]}, 32'd0);
      step(1'b1, 1'b1, 1'b0);
      check("t5_pwr_rst", {28'd0, clks_v[3]}, 32'hC);
      step(1'b0, 1'b0, 1'b0);
      check("t5_pwr_clear", {28'd0, clks_v[3]}, 32'h0);

      // Test 6: random soak, monitors do the checking
      for (int n = 0; n < 800; n++)
         step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) == 0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      mon_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
